// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Phase sequencer for a two-road intersection (north-south / east-west)
// with a pedestrian crossing and a night flashing-yellow mode. Everything
// runs on clk; the sequencer only advances on the one-cycle tick enable.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   tick        one-clk-wide advance enable (1 Hz nominal)
//   ped_req     pedestrian request (pulse or level), already synchronised
//   night_mode  level request for flashing-yellow operation
//   ns_light    north-south lamps {red,yellow,green}
//   ew_light    east-west lamps {red,yellow,green}
//   walk        pedestrian walk lamp
//   countdown   ticks remaining in the current phase minus 1 (0 in FLASH)
//   ped_pending latched pedestrian request awaiting service
module traffic_light_ctrl #(
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [CNT_W-1:0] countdown,
  output logic             ped_pending
);

  if (T_GREEN  < 1 || T_GREEN  >= (1 << CNT_W) ||
      T_YELLOW < 1 || T_YELLOW >= (1 << CNT_W) ||
      T_ALLRED < 1 || T_ALLRED >= (1 << CNT_W) ||
      T_WALK   < 1 || T_WALK   >= (1 << CNT_W)) begin : g_bad_duration
    $error("traffic_light_ctrl: every duration must be >=1 and <2^CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN  - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK   - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED1   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED2   = 3'd5,
    WALK      = 3'd6,
    FLASH     = 3'd7
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ped_nx;
  logic             flash_phase, flash_nx;

  // Lamp decode from (next) registered state only: {ns, ew, walk}.
  function automatic logic [6:0] decode(input state_t st, input logic fp);
    logic [2:0] ns, ew;
    logic       wk;
    ns = RED;
    ew = RED;
    wk = 1'b0;
    case (st)
      NS_GREEN:  ns = GRN;
      NS_YELLOW: ns = YEL;
      EW_GREEN:  ew = GRN;
      EW_YELLOW: ew = YEL;
      WALK:      wk = 1'b1;
      FLASH: begin
        ns = {1'b0, fp, 1'b0};
        ew = {1'b0, fp, 1'b0};
      end
      default: ;
    endcase
    return {ns, ew, wk};
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = countdown;
    flash_nx = flash_phase;
    // Requests are latched on any clock; in WALK the crossing is already served.
    ped_nx   = ped_pending | (ped_req & (state != WALK));
    if (tick) begin
      if (state == FLASH) begin
        flash_nx = ~flash_phase;
        cnt_nx   = '0;
        if (!night_mode) begin
          state_nx = ALLRED2;
          cnt_nx   = LD_ALLRED;
          flash_nx = 1'b0;
        end
      end else if (countdown != '0) begin
        cnt_nx = countdown - CNT_W'(1);
      end else begin
        case (state)
          NS_GREEN:  begin state_nx = NS_YELLOW; cnt_nx = LD_YELLOW; end
          NS_YELLOW: begin state_nx = ALLRED1;   cnt_nx = LD_ALLRED; end
          ALLRED1: begin
            if (night_mode) begin
              state_nx = FLASH;
              cnt_nx   = '0;
            end else begin
              state_nx = EW_GREEN;
              cnt_nx   = LD_GREEN;
            end
          end
          EW_GREEN:  begin state_nx = EW_YELLOW; cnt_nx = LD_YELLOW; end
          EW_YELLOW: begin state_nx = ALLRED2;   cnt_nx = LD_ALLRED; end
          ALLRED2: begin
            if (night_mode) begin
              state_nx = FLASH;
              cnt_nx   = '0;
            end else if (ped_pending || ped_req) begin
              state_nx = WALK;
              cnt_nx   = LD_WALK;
              ped_nx   = 1'b0;  // clearing on WALK entry beats a same-cycle request
            end else begin
              state_nx = NS_GREEN;
              cnt_nx   = LD_GREEN;
            end
          end
          WALK:      begin state_nx = NS_GREEN;  cnt_nx = LD_GREEN; end
          default:   begin state_nx = ALLRED2;   cnt_nx = LD_ALLRED; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALLRED2;
      countdown   <= LD_ALLRED;
      ped_pending <= 1'b0;
      flash_phase <= 1'b0;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
    end else begin
      state       <= state_nx;
      countdown   <= cnt_nx;
      ped_pending <= ped_nx;
      flash_phase <= flash_nx;
      {ns_light, ew_light, walk} <= decode(state_nx, flash_nx);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             ped_req;
  logic             night_mode;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic             walk;
  logic [CNT_W-1:0] countdown;
  logic             ped_pending;

  int n_cmp = 0;
  int n_mis = 0;

  traffic_light_ctrl #(
    .T_GREEN(25), .T_YELLOW(3), .T_ALLRED(2), .T_WALK(10), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
    .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .countdown(countdown), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  function automatic int ones3(input logic [2:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 3; i++)
      if (v[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                        input logic wk, input int cd);
    chk({tag, ".ns"}, 32'(ns_light), 32'(ns));
    chk({tag, ".ew"}, 32'(ew_light), 32'(ew));
    chk({tag, ".walk"}, 32'(walk), 32'(wk));
    chk({tag, ".cd"}, 32'(countdown), 32'(cd));
  endtask

  // One clock with the given tick value; outputs sampled 1 time unit after the edge.
  task automatic clk1(input logic t);
    logic flash_pat;
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    flash_pat = (ns_light == ew_light) && (ns_light == 3'b000 || ns_light == 3'b010);
    chk("onehot_ns", 32'(ones3(ns_light) == 1 || flash_pat), 32'd1);
    chk("onehot_ew", 32'(ones3(ew_light) == 1 || flash_pat), 32'd1);
    chk("safety", 32'((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00) && !flash_pat), 32'd0);
  endtask

  // One tick period: three idle clocks then the tick clock.
  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) clk1(1'b0);
      clk1(1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_st("rst", 3'b100, 3'b100, 1'b0, 1);
    chk("rst.ped", 32'(ped_pending), 32'd0);
    rst = 1'b0;

    // Reset release and one full 60-tick cycle.
    ticks(1);  chk_st("ar2_0", 3'b100, 3'b100, 1'b0, 0);
    ticks(1);  chk_st("nsg",   3'b001, 3'b100, 1'b0, 24);
    ticks(24); chk_st("nsg_0", 3'b001, 3'b100, 1'b0, 0);
    ticks(1);  chk_st("nsy",   3'b010, 3'b100, 1'b0, 2);
    ticks(3);  chk_st("ar1",   3'b100, 3'b100, 1'b0, 1);
    ticks(2);  chk_st("ewg",   3'b100, 3'b001, 1'b0, 24);
    ticks(25); chk_st("ewy",   3'b100, 3'b010, 1'b0, 2);
    ticks(3);  chk_st("ar2",   3'b100, 3'b100, 1'b0, 1);
    ticks(2);  chk_st("nsg2",  3'b001, 3'b100, 1'b0, 24);

    // Pedestrian pulse during EW_GREEN.
    ticks(30); chk_st("ewg2",  3'b100, 3'b001, 1'b0, 24);
    ticks(5);
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    chk("ped_latch", 32'(ped_pending), 32'd1);
    ticks(20); chk_st("ewy2",  3'b100, 3'b010, 1'b0, 2);
    ticks(4);  chk_st("ar2_p", 3'b100, 3'b100, 1'b0, 0);
    chk("ped_hold", 32'(ped_pending), 32'd1);
    ticks(1);  chk_st("walk",  3'b100, 3'b100, 1'b1, 9);
    chk("walk.ped", 32'(ped_pending), 32'd0);
    ticks(9);  chk_st("walk_0", 3'b100, 3'b100, 1'b1, 0);
    ticks(1);  chk_st("nsg3",  3'b001, 3'b100, 1'b0, 24);

    // Request on the ALLRED2 expiring tick itself, then held through WALK.
    ticks(30 + 29); chk_st("ar2_e", 3'b100, 3'b100, 1'b0, 0);
    chk("ar2_e.ped", 32'(ped_pending), 32'd0);
    repeat (3) clk1(1'b0);
    ped_req = 1'b1; clk1(1'b1);
    chk_st("walk_d", 3'b100, 3'b100, 1'b1, 9);
    chk("walk_d.ped", 32'(ped_pending), 32'd0);
    ticks(10); ped_req = 1'b0;
    chk_st("nsg4", 3'b001, 3'b100, 1'b0, 24);
    chk("nsg4.ped", 32'(ped_pending), 32'd0);
    ticks(60); chk_st("nsg5", 3'b001, 3'b100, 1'b0, 24);

    // Night mode: green and yellow complete, then FLASH.
    ticks(5); night_mode = 1'b1;
    ticks(20); chk_st("n_nsy", 3'b010, 3'b100, 1'b0, 2);
    ticks(3);  chk_st("n_ar1", 3'b100, 3'b100, 1'b0, 1);
    ticks(2);  chk_st("fl0",   3'b000, 3'b000, 1'b0, 0);
    ticks(1);  chk_st("fl1",   3'b010, 3'b010, 1'b0, 0);
    ticks(1);  chk_st("fl2",   3'b000, 3'b000, 1'b0, 0);
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    chk("fl.ped", 32'(ped_pending), 32'd1);
    ticks(1);  chk_st("fl3",   3'b010, 3'b010, 1'b0, 0);
    night_mode = 1'b0;
    ticks(1);  chk_st("fl_ar2", 3'b100, 3'b100, 1'b0, 1);
    ticks(2);  chk_st("fl_walk", 3'b100, 3'b100, 1'b1, 9);
    ticks(10); chk_st("nsg6",  3'b001, 3'b100, 1'b0, 24);

    // Async reset mid EW_GREEN at countdown 10.
    ticks(30 + 14); chk_st("ewg10", 3'b100, 3'b001, 1'b0, 10);
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    chk("ewg10.ped", 32'(ped_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_st("arst", 3'b100, 3'b100, 1'b0, 1);
    chk("arst.ped", 32'(ped_pending), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    ticks(2); chk_st("arst_nsg", 3'b001, 3'b100, 1'b0, 24);

    // Tick gating and back-to-back ticks.
    repeat (1000) clk1(1'b0);
    chk_st("idle", 3'b001, 3'b100, 1'b0, 24);
    clk1(1'b1); chk("b2b1", 32'(countdown), 32'd23);
    clk1(1'b1); chk("b2b2", 32'(countdown), 32'd22);
    clk1(1'b1); chk("b2b3", 32'(countdown), 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
